// File: rtl/sram_memory_controller_if.sv
// Pipeline-side load/store port of the SRAM memory controller.
//   readEnabled  : load request from the EX/MEM register
//   writeEnabled : store request from the EX/MEM register (wins over readEnabled)
//   address      : byte address (ALU result)
//   writeData    : store data (valRm)
//   readData     : registered load result
//   ready        : 1 = pipeline may advance, 0 = freeze all stages
// The master modport is the pipeline side. The slave modport is the controller side.
interface sram_memory_controller_if;
  logic        readEnabled;
  logic        writeEnabled;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        ready;

  modport master (
    output readEnabled, writeEnabled, address, writeData,
    input  readData, ready
  );

  modport slave (
    input  readEnabled, writeEnabled, address, writeData,
    output readData, ready
  );
endinterface

// File: rtl/sram_memory_controller.sv
// SRAM memory controller.
// Serves 32-bit loads and stores from the execution stage. Each word access is
// split into two 16-bit accesses to an external SRAM: the low half first, then
// the high half. While an access is in flight, ready is held low so that the
// pipeline freezes.
// Ports:
//   clk            : rising-edge clock
//   rst_n          : asynchronous active-low reset
//   bus            : load/store request interface (slave modport)
//   sramAddress_o  : SRAM halfword address
//   sramDqOut_o    : SRAM write data
//   sramDqIn_i     : SRAM read data
//   sramDqOe_o     : 1 = drive sramDqOut_o onto the SRAM data bus
//   sramWeN_o      : SRAM write enable, active-low
module sram_memory_controller #(
  parameter int unsigned BASE_ADDRESS    = 1024,
  parameter int unsigned SRAM_ADDR_WIDTH = 18,
  parameter int unsigned ACCESS_CYCLES   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  sram_memory_controller_if.slave    bus,
  output logic [SRAM_ADDR_WIDTH-1:0] sramAddress_o,
  output logic [15:0]                sramDqOut_o,
  input  logic [15:0]                sramDqIn_i,
  output logic                       sramDqOe_o,
  output logic                       sramWeN_o
);

  // The cycle counter is 4 bits wide, so a half access cannot exceed 15 cycles.
  // The last-cycle write-enable release also needs at least 2 cycles per half.
  if (ACCESS_CYCLES < 2 || ACCESS_CYCLES > 15) begin : gen_bad_cycles
    $error("ACCESS_CYCLES must be in 2..15");
  end

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOW  = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [3:0] LAST_CYCLE = 4'(ACCESS_CYCLES - 1);

  logic [1:0]                 state_q,    state_d;
  logic [3:0]                 cnt_q,      cnt_d;
  logic                       isWrite_q,  isWrite_d;
  logic [SRAM_ADDR_WIDTH-2:0] wordAddr_q, wordAddr_d;
  logic [31:0]                wrData_q,   wrData_d;
  logic [15:0]                temp_q,     temp_d;
  logic [31:0]                readData_q, readData_d;

  logic        request;
  logic        lastCycle;
  logic [31:0] offset;
  logic        unusedOffsetBits;

  assign request   = bus.readEnabled | bus.writeEnabled;
  assign lastCycle = (cnt_q == LAST_CYCLE);

  // The offset is taken modulo 2^32 with no range check. Out-of-range addresses
  // wrap into the SRAM. The byte-in-word bits and the bits above the SRAM
  // window are intentionally dropped.
  assign offset           = bus.address - BASE_ADDRESS;
  assign unusedOffsetBits = ^{offset[31:SRAM_ADDR_WIDTH+1], offset[1:0]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    isWrite_d  = isWrite_q;
    wordAddr_d = wordAddr_q;
    wrData_d   = wrData_q;
    temp_d     = temp_q;
    readData_d = readData_q;
    case (state_q)
      IDLE: begin
        // Requests are captured only here, so input changes during an
        // access (including a dropped request) do not affect it.
        if (request) begin
          isWrite_d  = bus.writeEnabled;
          wordAddr_d = offset[SRAM_ADDR_WIDTH:2];
          wrData_d   = bus.writeData;
          cnt_d      = '0;
          state_d    = LOW;
        end
      end
      LOW: begin
        if (lastCycle) begin
          if (!isWrite_q) temp_d = sramDqIn_i;
          cnt_d   = '0;
          state_d = HIGH;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HIGH: begin
        // readData is updated only here, so it holds across writes and idles.
        if (lastCycle) begin
          if (!isWrite_q) readData_d = {sramDqIn_i, temp_q};
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      isWrite_q  <= 1'b0;
      wordAddr_q <= '0;
      wrData_q   <= '0;
      temp_q     <= '0;
      readData_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      isWrite_q  <= isWrite_d;
      wordAddr_q <= wordAddr_d;
      wrData_q   <= wrData_d;
      temp_q     <= temp_d;
      readData_q <= readData_d;
    end
  end

  // SRAM pins are decoded from the state register. During a write, the
  // write-enable is released on the last cycle of each half, so that the
  // address and data are still held while the write strobe rises.
  always_comb begin
    sramAddress_o = '0;
    sramDqOut_o   = '0;
    sramDqOe_o    = 1'b0;
    sramWeN_o     = 1'b1;
    case (state_q)
      LOW: begin
        sramAddress_o = {wordAddr_q, 1'b0};
        if (isWrite_q) begin
          sramDqOe_o  = 1'b1;
          sramDqOut_o = wrData_q[15:0];
          sramWeN_o   = lastCycle;
        end
      end
      HIGH: begin
        sramAddress_o = {wordAddr_q, 1'b1};
        if (isWrite_q) begin
          sramDqOe_o  = 1'b1;
          sramDqOut_o = wrData_q[31:16];
          sramWeN_o   = lastCycle;
        end
      end
      default: ;
    endcase
  end

  // A request seen in IDLE costs one cycle of ready=0 before the access starts.
  assign bus.ready    = ((state_q == IDLE) && !request) || (state_q == DONE);
  assign bus.readData = readData_q;

endmodule

// File: tb/tb_sram_memory_controller.sv
// Self-checking bench for sram_memory_controller.
// dutA uses the default timing (2 cycles per half) and dutB uses 3 cycles per half.
// Each DUT is attached to its own behavioural SRAM array. Expected values come
// from a table, or from a word-level memory model.
module tb_sram_memory_controller;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sram_memory_controller_if busA ();
  sram_memory_controller_if busB ();

  logic [17:0] sramAddrA, sramAddrB;
  logic [15:0] dqOutA, dqOutB, dqInA, dqInB;
  logic        oeA, oeB, weNA, weNB;

  bit [15:0] memA [0:262143];
  bit [15:0] memB [0:262143];

  assign dqInA = memA[sramAddrA];
  assign dqInB = memB[sramAddrB];
  always @(posedge clk) if (oeA && !weNA) memA[sramAddrA] <= dqOutA;
  always @(posedge clk) if (oeB && !weNB) memB[sramAddrB] <= dqOutB;

  sram_memory_controller #(.BASE_ADDRESS(1024), .SRAM_ADDR_WIDTH(18), .ACCESS_CYCLES(2)) dutA (
    .clk(clk), .rst_n(rst_n), .bus(busA),
    .sramAddress_o(sramAddrA), .sramDqOut_o(dqOutA), .sramDqIn_i(dqInA),
    .sramDqOe_o(oeA), .sramWeN_o(weNA)
  );

  sram_memory_controller #(.BASE_ADDRESS(1024), .SRAM_ADDR_WIDTH(18), .ACCESS_CYCLES(3)) dutB (
    .clk(clk), .rst_n(rst_n), .bus(busB),
    .sramAddress_o(sramAddrB), .sramDqOut_o(dqOutB), .sramDqIn_i(dqInB),
    .sramDqOe_o(oeB), .sramWeN_o(weNB)
  );

  int errors = 0;
  int checks = 0;

  // Word-level reference: one 32-bit entry per SRAM word, plus the last load result.
  logic [31:0] refMem [int unsigned];
  logic [31:0] refReadData = 32'h0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [17:0] expLow;
    logic [31:0] expRead;
  } vec_t;

  vec_t vecs [9];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic int unsigned wordIndex(input logic [31:0] addr);
    return ((addr - 32'd1024) >> 2) & 32'h1FFFF;
  endfunction

  function automatic logic [31:0] modelRead(input int unsigned idx);
    return refMem.exists(idx) ? refMem[idx] : 32'h0;
  endfunction

  function automatic void modelAccess(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
    int unsigned idx = wordIndex(addr);
    if (wr) refMem[idx] = data;
    else if (rd) refReadData = modelRead(idx);
  endfunction

  // Called just after a rising edge, with dutA idle. Returns the number of
  // ready=0 cycles, the halfword addresses seen in LOW and HIGH, the number of
  // write-strobe cycles, and readData sampled in the ready=1 cycle.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data,
                               output int cycles, output logic [17:0] lowAddr, output logic [17:0] highAddr,
                               output int weLow, output logic [31:0] rdata);
    busA.readEnabled  = rd;
    busA.writeEnabled = wr;
    busA.address      = addr;
    busA.writeData    = data;
    cycles = 0; weLow = 0; lowAddr = '0; highAddr = '0;
    @(negedge clk);
    while (busA.ready !== 1'b1 && cycles < 40) begin
      if (cycles == 1) lowAddr = sramAddrA;
      if (cycles == 3) highAddr = sramAddrA;
      if (weNA === 1'b0) weLow++;
      cycles++;
      @(negedge clk);
    end
    rdata = busA.readData;
    @(posedge clk); #1;
    busA.readEnabled  = 1'b0;
    busA.writeEnabled = 1'b0;
  endtask

  task automatic checkAccess(input string tag, input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] data, input logic [17:0] expLow, input logic [31:0] expRead);
    int cycles, weLow;
    logic [17:0] lowAddr, highAddr;
    logic [31:0] rdata;
    applyStimulus(rd, wr, addr, data, cycles, lowAddr, highAddr, weLow, rdata);
    checkOutput({tag, " readyLowCycles"}, 32'(cycles), 32'd5);
    checkOutput({tag, " lowAddr"}, 32'(lowAddr), 32'(expLow));
    checkOutput({tag, " highAddr"}, 32'(highAddr), 32'(expLow | 18'd1));
    checkOutput({tag, " weStrobes"}, 32'(weLow), wr ? 32'd2 : 32'd0);
    checkOutput({tag, " readData"}, rdata, expRead);
    if (wr) begin
      checkOutput({tag, " sramLow"}, 32'(memA[expLow]), 32'(data[15:0]));
      checkOutput({tag, " sramHigh"}, 32'(memA[expLow | 18'd1]), 32'(data[31:16]));
    end
  endtask

  task automatic applyStimulusB(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data,
                                output int cycles);
    busB.readEnabled  = rd;
    busB.writeEnabled = wr;
    busB.address      = addr;
    busB.writeData    = data;
    cycles = 0;
    @(negedge clk);
    while (busB.ready !== 1'b1 && cycles < 40) begin
      cycles++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    busB.readEnabled  = 1'b0;
    busB.writeEnabled = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cycles;
    logic [15:0] pattern;
    logic [31:0] rd1, rd2;

    vecs[0] = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 18'd0,       32'h00000000};
    vecs[1] = '{1'b1, 1'b0, 32'd1024, 32'h00000000, 18'd0,       32'hDEADBEEF};
    vecs[2] = '{1'b0, 1'b1, 32'd1028, 32'h12345678, 18'd2,       32'hDEADBEEF};
    vecs[3] = '{1'b1, 1'b0, 32'd1025, 32'h00000000, 18'd0,       32'hDEADBEEF};
    vecs[4] = '{1'b1, 1'b0, 32'd1028, 32'h00000000, 18'd2,       32'h12345678};
    vecs[5] = '{1'b0, 1'b1, 32'd0,    32'hCAFEF00D, 18'h3FE00,   32'h12345678};
    vecs[6] = '{1'b1, 1'b0, 32'd3,    32'h00000000, 18'h3FE00,   32'hCAFEF00D};
    vecs[7] = '{1'b1, 1'b1, 32'd1028, 32'hAAAA5555, 18'd2,       32'hCAFEF00D};
    vecs[8] = '{1'b1, 1'b0, 32'd1031, 32'h00000000, 18'd2,       32'hAAAA5555};

    busA.readEnabled = 1'b0; busA.writeEnabled = 1'b0; busA.address = '0; busA.writeData = '0;
    busB.readEnabled = 1'b0; busB.writeEnabled = 1'b0; busB.address = '0; busB.writeData = '0;
    rst_n = 1'b0;
    #12;
    checkOutput("reset ready", 32'(busA.ready), 32'd1);
    checkOutput("reset weN", 32'(weNA), 32'd1);
    checkOutput("reset oe", 32'(oeA), 32'd0);
    checkOutput("reset sramAddress", 32'(sramAddrA), 32'd0);
    checkOutput("reset readData", busA.readData, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset asserted in the middle of the LOW half of a write.
    busA.writeEnabled = 1'b1; busA.address = 32'd1024; busA.writeData = 32'h12345678;
    @(negedge clk);
    @(negedge clk);
    checkOutput("midLow weN", 32'(weNA), 32'd0);
    rst_n = 1'b0;
    busA.writeEnabled = 1'b0;
    #1;
    checkOutput("midReset weN", 32'(weNA), 32'd1);
    checkOutput("midReset oe", 32'(oeA), 32'd0);
    checkOutput("midReset ready", 32'(busA.ready), 32'd1);
    checkOutput("midReset readData", busA.readData, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] table vectors");
    for (int i = 0; i < 9; i++) begin
      checkAccess($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data,
                  vecs[i].expLow, vecs[i].expRead);
      modelAccess(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data);
    end
    @(negedge clk);
    checkOutput("idle readData hold", busA.readData, 32'hAAAA5555);
    checkOutput("idle ready", 32'(busA.ready), 32'd1);
    @(posedge clk); #1;

    $display("[TB] randomized accesses");
    for (int i = 0; i < 40; i++) begin
      int unsigned op;
      logic rd, wr;
      logic [31:0] addr, data, expRead;
      op   = $urandom_range(0, 2);
      rd   = (op != 1);
      wr   = (op != 0);
      addr = 32'd1024 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      data = $urandom;
      expRead = wr ? refReadData : modelRead(wordIndex(addr));
      checkAccess($sformatf("rnd%0d", i), rd, wr, addr, data, 18'(wordIndex(addr) * 2), expRead);
      modelAccess(rd, wr, addr, data);
    end

    // A store request that is dropped while in the HIGH half must still complete.
    busA.writeEnabled = 1'b1; busA.address = 32'd1032; busA.writeData = 32'h0BADF00D;
    cycles = 0;
    @(negedge clk);
    while (busA.ready !== 1'b1 && cycles < 40) begin
      if (cycles == 3) busA.writeEnabled = 1'b0;
      cycles++;
      @(negedge clk);
    end
    checkOutput("dropped latency", 32'(cycles), 32'd5);
    @(posedge clk); #1;
    busA.writeEnabled = 1'b0;
    checkOutput("dropped sramLow", 32'(memA[4]), 32'h0000F00D);
    checkOutput("dropped sramHigh", 32'(memA[5]), 32'h00000BAD);

    $display("[TB] three-cycle instance");
    applyStimulusB(1'b0, 1'b1, 32'd1024, 32'h22221111, cycles);
    checkOutput("B store0 latency", 32'(cycles), 32'd7);
    applyStimulusB(1'b0, 1'b1, 32'd1028, 32'h44443333, cycles);
    checkOutput("B store1 latency", 32'(cycles), 32'd7);
    checkOutput("B sram0", 32'(memB[0]), 32'h00001111);
    checkOutput("B sram3", 32'(memB[3]), 32'h00004444);

    busB.readEnabled = 1'b1; busB.address = 32'd1024;
    pattern = '0; rd1 = '0; rd2 = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      pattern[i] = busB.ready;
      if (i == 7) begin
        rd1 = busB.readData;
        @(posedge clk); #1;
        busB.address = 32'd1028;
      end
      if (i == 15) rd2 = busB.readData;
    end
    @(posedge clk); #1;
    busB.readEnabled = 1'b0;
    checkOutput("B b2b readyPattern", 32'(pattern), 32'h00008080);
    checkOutput("B b2b load0", rd1, 32'h22221111);
    checkOutput("B b2b load1", rd2, 32'h44443333);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
